// File: rtl/ad7606_ctrl.sv
// ad7606_ctrl: parallel-interface read controller for the AD7606 8-channel ADC.
// Sequences the ADC RESET pin after system reset, issues CONVST on request,
// waits out BUSY, strobes CS/RD across the eight channels and forwards each
// 16-bit result as a channel-tagged stream beat.
//
// Build option: define AD7606_FRSTDATA_CHECK_EN to check FRSTDATA at every
// capture and report a mismatch on err_frst_o. Without it frstdata_i is ignored
// and err_frst_o is tied low.
`timescale 1ns/1ps

module ad7606_ctrl #(
    parameter int RESET_CYC        = 8,
    parameter int CONVST_LOW_CYC   = 2,
    parameter int RD_LOW_CYC       = 3,
    parameter int RD_HIGH_CYC      = 2,
    parameter int BUSY_RISE_CYC    = 16,
    parameter int BUSY_TIMEOUT_CYC = 40000
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    input  logic [2:0]  os_i,
    output logic        ctrl_busy_o,
    output logic        adc_reset_o,
    output logic        convst_o,
    output logic        cs_n_o,
    output logic        rd_n_o,
    output logic [2:0]  os_o,
    input  logic [15:0] db_i,
    input  logic        busy_i,
    input  logic        frstdata_i,
    output logic [15:0] sample_data_o,
    output logic [2:0]  sample_chan_o,
    output logic        sample_valid_o,
    input  logic        sample_ready_i,
    output logic        err_timeout_o,
    output logic        err_frst_o,
    output logic [2:0]  dbg_state_o
);

    // Stream handshake: a beat transfers on a rising clk_i edge where
    // sample_valid_o and sample_ready_i are both high. Once sample_valid_o is
    // raised, sample_data_o/sample_chan_o hold steady until that transfer;
    // valid never drops without a transfer (except on reset).

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The rise window is widened by the synchronizer depth so a BUSY edge on
    // the last allowed raw cycle is still seen before the timeout fires.
    localparam int RISE_LIMIT = BUSY_RISE_CYC + 1;
    localparam int CNT_MAX    = max2(max2(max2(RESET_CYC, BUSY_TIMEOUT_CYC),
                                          max2(RISE_LIMIT, CONVST_LOW_CYC)),
                                     max2(RD_LOW_CYC, RD_HIGH_CYC));
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_ADC_RST      = 3'd0,
        ST_IDLE         = 3'd1,
        ST_CONVST       = 3'd2,
        ST_WAIT_BUSY_HI = 3'd3,
        ST_WAIT_BUSY_LO = 3'd4,
        ST_RD_LOW       = 3'd5,
        ST_RD_HIGH      = 3'd6,
        ST_DONE         = 3'd7
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         chan_q;
    logic               last_q;
    logic               busy_meta_q;
    logic               busy_sync_q;
    logic               can_load;

`ifndef AD7606_FRSTDATA_CHECK_EN
    logic               frst_unused;
    assign frst_unused = frstdata_i;
    assign err_frst_o  = 1'b0;
`endif

    // A new capture may only start when the output register is empty or is
    // being emptied in this very cycle.
    assign can_load    = !sample_valid_o || sample_ready_i;
    assign ctrl_busy_o = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

    // Two-flop synchronizer for the asynchronous ADC BUSY pin.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            busy_meta_q <= 1'b0;
            busy_sync_q <= 1'b0;
        end else begin
            busy_meta_q <= busy_i;
            busy_sync_q <= busy_meta_q;
        end
    end

    // Main control FSM with registered ADC pins and output stream register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= ST_ADC_RST;
            cnt_q          <= '0;
            chan_q         <= 3'd0;
            last_q         <= 1'b0;
            adc_reset_o    <= 1'b0;
            convst_o       <= 1'b1;
            cs_n_o         <= 1'b1;
            rd_n_o         <= 1'b1;
            os_o           <= 3'd0;
            sample_data_o  <= 16'd0;
            sample_chan_o  <= 3'd0;
            sample_valid_o <= 1'b0;
            err_timeout_o  <= 1'b0;
`ifdef AD7606_FRSTDATA_CHECK_EN
            err_frst_o     <= 1'b0;
`endif
        end else begin
            // Drain the output register on a handshake; a capture below
            // in the same cycle re-arms it.
            if (sample_valid_o && sample_ready_i) begin
                sample_valid_o <= 1'b0;
            end

            case (state_q)
                ST_ADC_RST: begin
                    if (cnt_q == CNT_W'(RESET_CYC)) begin
                        adc_reset_o <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= ST_IDLE;
                    end else begin
                        adc_reset_o <= 1'b1;
                        cnt_q       <= cnt_q + CNT_W'(1);
                    end
                end

                ST_IDLE: begin
                    if (start_i) begin
                        os_o          <= os_i;
                        err_timeout_o <= 1'b0;
`ifdef AD7606_FRSTDATA_CHECK_EN
                        err_frst_o    <= 1'b0;
`endif
                        convst_o      <= 1'b0;
                        cnt_q         <= CNT_W'(1);
                        state_q       <= ST_CONVST;
                    end
                end

                ST_CONVST: begin
                    if (cnt_q == CNT_W'(CONVST_LOW_CYC)) begin
                        convst_o <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= ST_WAIT_BUSY_HI;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_WAIT_BUSY_HI: begin
                    if (busy_sync_q) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_BUSY_LO;
                    end else if (cnt_q == CNT_W'(RISE_LIMIT)) begin
                        err_timeout_o <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_WAIT_BUSY_LO: begin
                    // Parking in RD_HIGH with its hold already satisfied gives
                    // one cycle of CS-to-RD setup and applies the
                    // output-register gate to channel 0 as well (the previous
                    // frame's last beat may still be pending).
                    if (!busy_sync_q) begin
                        cs_n_o  <= 1'b0;
                        chan_q  <= 3'd0;
                        last_q  <= 1'b0;
                        cnt_q   <= CNT_W'(RD_HIGH_CYC - 1);
                        state_q <= ST_RD_HIGH;
                    end else if (cnt_q == CNT_W'(BUSY_TIMEOUT_CYC - 1)) begin
                        err_timeout_o <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_RD_LOW: begin
                    if (cnt_q == CNT_W'(RD_LOW_CYC - 1)) begin
                        sample_data_o  <= db_i;
                        sample_chan_o  <= chan_q;
                        sample_valid_o <= 1'b1;
`ifdef AD7606_FRSTDATA_CHECK_EN
                        if (frstdata_i != (chan_q == 3'd0)) begin
                            err_frst_o <= 1'b1;
                        end
`endif
                        rd_n_o  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_RD_HIGH;
                        if (chan_q == 3'd7) begin
                            last_q <= 1'b1;
                        end else begin
                            chan_q <= chan_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_RD_HIGH: begin
                    if (cnt_q >= CNT_W'(RD_HIGH_CYC - 1)) begin
                        if (last_q) begin
                            state_q <= ST_DONE;
                        end else if (can_load) begin
                            rd_n_o  <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= ST_RD_LOW;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    cs_n_o  <= 1'b1;
                    last_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_ADC_RST;
                end
            endcase
        end
    end

endmodule

// File: doc/ad7606_ctrl.md
# ad7606_ctrl

Synthesizable read controller for the AD7606 8-channel simultaneous-sampling ADC, sitting directly between the ADC pins and the on-FPGA sample stream. On each accepted start request it pulses CONVST, waits out BUSY and reads all eight channels in parallel-interface mode (CS/RD strobing). It then emits each 16-bit result as a channel-tagged valid/ready beat. It also sequences the ADC RESET pin after system reset, forwards the oversampling selection and reports BUSY timeouts.

## Interface
Parameters:
- RESET_CYC, 8 — cycles adc_reset_o is held high after reset release.
- CONVST_LOW_CYC, 2 — cycles convst_o is held low before its start-of-conversion rising edge.
- RD_LOW_CYC, 3 — cycles rd_n_o is low per channel; db_i is captured on the last low cycle; must be ≥ 2.
- RD_HIGH_CYC, 2 — minimum cycles rd_n_o is high between channels.
- BUSY_RISE_CYC, 16 — cycles allowed for busy_i to rise after the convst_o rising edge.
- BUSY_TIMEOUT_CYC, 40000 — cycles allowed for busy_i to fall once high.

Ports:
- clk_i  in  1  system clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle conversion request.
- os_i  in  3  oversampling code, latched when start_i is accepted.
- ctrl_busy_o  out  1  high whenever the FSM is not in IDLE.
- adc_reset_o  out  1  ADC RESET pin, active high.
- convst_o  out  1  ADC CONVST A/B, idle high.
- cs_n_o  out  1  ADC chip select.
- rd_n_o  out  1  ADC read strobe.
- os_o  out  3  ADC OS[2:0] pins.
- db_i  in  16  ADC data bus.
- busy_i  in  1  ADC BUSY (asynchronous).
- frstdata_i  in  1  ADC FRSTDATA.
- sample_data_o  out  16  captured result.
- sample_chan_o  out  3  channel index of the result, 0..7.
- sample_valid_o  out  1  result available.
- sample_ready_i  in  1  consumer accepts the result.
- err_timeout_o  out  1  sticky flag for a BUSY rise or fall timeout.
- err_frst_o  out  1  sticky flag for a FRSTDATA mismatch (present only with the macro).

## Operation
- busy_i passes through a 2-flop synchronizer. db_i and frstdata_i are sampled raw at the capture edge; they are stable while rd_n_o is low.
- FSM states: ADC_RST, IDLE, CONVST, WAIT_BUSY_HI, WAIT_BUSY_LO, RD_LOW, RD_HIGH, DONE.
- ADC_RST: adc_reset_o=1 for RESET_CYC cycles, then go to IDLE.
- IDLE: when start_i=1, latch os_i into os_o, clear both error flags and go to CONVST. A start_i in any other state is ignored.
- CONVST: convst_o=0 for CONVST_LOW_CYC cycles, then return it high and go to WAIT_BUSY_HI.
- WAIT_BUSY_HI: go to WAIT_BUSY_LO when the synchronized busy is seen high. If BUSY_RISE_CYC cycles elapse first, set err_timeout_o and go to IDLE.
- WAIT_BUSY_LO: when the synchronized busy is seen low, assert cs_n_o=0, set chan=0 and go to RD_LOW. If BUSY_TIMEOUT_CYC cycles elapse first, set err_timeout_o and go to IDLE.
- RD_LOW entry condition: the output register must be empty, i.e. sample_valid_o=0 or it is being accepted this cycle. Otherwise the FSM holds in RD_HIGH with rd_n_o=1.
- RD_LOW: rd_n_o=0 for RD_LOW_CYC cycles. On the last cycle, load sample_data_o=db_i and sample_chan_o=chan, and set sample_valid_o=1. rd_n_o then returns high and the FSM goes to RD_HIGH.
- RD_HIGH: hold at least RD_HIGH_CYC cycles. If chan=7, go to DONE; otherwise increment chan and re-enter RD_LOW, subject to the entry condition.
- DONE: cs_n_o=1, go to IDLE. The final sample may still be pending on the stream.
- Stream rule: sample_data_o and sample_chan_o stay stable while sample_valid_o=1 and sample_ready_i=0. sample_valid_o clears on the handshake unless a new capture lands in the same cycle.

## Timing
- Reset values: adc_reset_o=0, convst_o=1, cs_n_o=1, rd_n_o=1, os_o=0, sample_data_o=0, sample_chan_o=0, sample_valid_o=0, ctrl_busy_o=1 (the FSM resets into ADC_RST), err_timeout_o=0, err_frst_o=0.
- Reset release: adc_reset_o rises in the first cycle after reset_n_i is deasserted.
- Start to convst_o low: 1 cycle.
- convst_o rising edge: CONVST_LOW_CYC cycles after it falls.
- busy_i detection latency: 2 cycles, due to the synchronizer.
- busy_i low (synchronized) to cs_n_o low: 1 cycle.
- cs_n_o low to the first rd_n_o fall: 1 cycle.
- Unstalled frame read: 8·(RD_LOW_CYC+RD_HIGH_CYC) cycles.
- Reset asserted mid-operation: all outputs take their reset values immediately, and the ADC reset sequence is repeated after release.

## Configuration
- AD7606_FRSTDATA_CHECK_EN defined:
  - At each capture, frstdata_i must be 1 for chan=0 and 0 for chan=1..7.
  - Any mismatch sets err_frst_o (sticky until the next accepted start). The frame still completes.
- AD7606_FRSTDATA_CHECK_EN undefined:
  - frstdata_i is ignored.
  - err_frst_o is tied to 0.

## Test plan
- Reset, then os_i=0 and start_i pulse, sample_ready_i=1 → adc_reset_o high for 8 cycles, one convst_o low pulse, then eight beats with sample_chan_o 0..7 matching the ADC model's db values, and ctrl_busy_o low after DONE.
- os_i=3'b110 → os_o=6, BUSY held about 315 µs with no timeout, and 8 beats.
- busy_i tied low → err_timeout_o set 2+16 cycles after the convst_o rising edge, FSM returns to IDLE, and cs_n_o never goes low.
- sample_ready_i low for 50 cycles after chan 2 is captured → rd_n_o stays high during the stall, chan 2 data is held stable, and there is no lost or duplicated channel.
- start_i re-pulsed during a read, then reset_n_i asserted at chan 4 → the extra start is ignored, and on reset all outputs go to reset values and the ADC reset sequence repeats.
- With AD7606_FRSTDATA_CHECK_EN, force frstdata_i=0 at chan 0 → err_frst_o=1 and all 8 samples are still delivered.
